// File: rtl/data_mem_pkg.sv
// Shared types and helpers for the byte-addressable data memory unit.
package data_mem_pkg;

    localparam logic [1:0] SZ_BYTE  = 2'd0;
    localparam logic [1:0] SZ_HALF  = 2'd1;
    localparam logic [1:0] SZ_WORD  = 2'd2;
    localparam logic [1:0] SZ_DWORD = 2'd3;

    typedef enum logic {ST_INIT, ST_RUN} state_e;

    // Byte-enable mask over up to 8 lanes; callers keep only the lanes they have.
    function automatic logic [7:0] byte_en(input logic [1:0] size, input logic [2:0] off);
        logic [7:0] base;
        case (size)
            SZ_BYTE: base = 8'h01;
            SZ_HALF: base = 8'h03;
            SZ_WORD: base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/data_mem_lane_align.sv
// Combinational lane steering: store shift and byte enables, load extract and extend.
module data_mem_lane_align
    import data_mem_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic [1:0]         i_st_size,
    input  logic [2:0]         i_st_off,
    input  logic [WIDTH-1:0]   i_st_data,
    output logic [WIDTH-1:0]   o_st_data,
    output logic [WIDTH/8-1:0] o_st_be,
    input  logic [1:0]         i_ld_size,
    input  logic               i_ld_unsigned,
    input  logic [2:0]         i_ld_off,
    input  logic [WIDTH-1:0]   i_ld_word,
    output logic [WIDTH-1:0]   o_ld_data
);

    localparam int unsigned B = WIDTH / 8;

    logic [7:0]       w_be8;
    logic [WIDTH-1:0] w_sh;
    logic [WIDTH-1:0] w_mask;
    logic [3:0]       w_nbytes;
    logic             w_sign;

    assign w_be8     = byte_en(i_st_size, i_st_off);
    assign o_st_be   = w_be8[B-1:0];
    assign o_st_data = i_st_data << {i_st_off, 3'b000};

    assign w_sh      = i_ld_word >> {i_ld_off, 3'b000};
    assign w_nbytes  = 4'd1 << i_ld_size;

    // The sign bit is the MSB of the highest byte inside the loaded field.
    always_comb begin
        w_mask = '0;
        w_sign = 1'b0;
        for (int i = 0; i < int'(B); i++) begin
            if (i < int'(w_nbytes)) begin
                w_mask[i*8 +: 8] = 8'hFF;
                w_sign           = w_sh[i*8+7];
            end
        end
        if (int'(w_nbytes) >= int'(B)) begin
            o_ld_data = w_sh;
        end else begin
            o_ld_data = (w_sh & w_mask) | ((w_sign && !i_ld_unsigned) ? ~w_mask : '0);
        end
    end

endmodule

// File: rtl/data_mem_unit.sv
// Byte-addressable data memory with init sequencer, error checks and a fixed-latency
// response pipeline.
module data_mem_unit
    import data_mem_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned DEPTH    = 512,
    parameter int unsigned READ_LAT = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_write,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      Address,
    input  logic [WIDTH-1:0] WriteData,
    output logic             resp_valid,
    output logic [WIDTH-1:0] ReadData,
    output logic             resp_err,
    output logic             init_done
);

    localparam int unsigned B  = WIDTH / 8;
    localparam int unsigned LB = $clog2(B);
    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [IW-1:0] CNT_LAST = IW'(DEPTH - 1);

    state_e          r_state;
    state_e          w_state_next;
    logic [IW-1:0]   r_cnt;
    logic [IW-1:0]   w_cnt_next;

    logic [WIDTH-1:0] r_mem [DEPTH];

    logic [2:0]       w_off;
    logic [IW-1:0]    w_idx;
    logic             w_misalign;
    logic             w_bad_size;
    logic             w_range_err;
    logic             w_err;
    logic             w_accept;
    logic [WIDTH-1:0] w_st_data;
    logic [B-1:0]     w_st_be;
    logic [WIDTH-1:0] w_ld_data;

    logic             r_pv    [READ_LAT];
    logic             r_pe    [READ_LAT];
    logic             r_pload [READ_LAT];
    logic [1:0]       r_psz   [READ_LAT];
    logic             r_puns  [READ_LAT];
    logic [2:0]       r_poff  [READ_LAT];
    logic [WIDTH-1:0] r_pword [READ_LAT];

    // ---------------- init sequencer ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_INIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_INIT: begin
                w_cnt_next = r_cnt + 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN:  w_state_next = ST_RUN;
            default: w_state_next = ST_INIT;
        endcase
    end

    assign req_ready = (r_state == ST_RUN);
    assign init_done = (r_state == ST_RUN);
    assign w_accept  = req_valid && req_ready;

    // ---------------- request decode ----------------
    always_comb begin
        w_off         = '0;
        w_off[LB-1:0] = Address[LB-1:0];
    end

    assign w_idx       = Address[LB +: IW];
    assign w_range_err = (Address >> (LB + IW)) != '0;
    assign w_bad_size  = (req_size == SZ_DWORD) && (WIDTH == 32);

    always_comb begin
        case (req_size)
            SZ_HALF:  w_misalign = w_off[0];
            SZ_WORD:  w_misalign = |w_off[1:0];
            SZ_DWORD: w_misalign = |w_off[2:0];
            default:  w_misalign = 1'b0;
        endcase
    end

    assign w_err = w_misalign || w_bad_size || w_range_err;

    data_mem_lane_align #(
        .WIDTH (WIDTH)
    ) u_lane_align (
        .i_st_size     (req_size),
        .i_st_off      (w_off),
        .i_st_data     (WriteData),
        .o_st_data     (w_st_data),
        .o_st_be       (w_st_be),
        .i_ld_size     (r_psz[READ_LAT-1]),
        .i_ld_unsigned (r_puns[READ_LAT-1]),
        .i_ld_off      (r_poff[READ_LAT-1]),
        .i_ld_word     (r_pword[READ_LAT-1]),
        .o_ld_data     (w_ld_data)
    );

    // ---------------- array and read data path ----------------
    // Read happens in the acceptance cycle, so a store one cycle earlier is already visible.
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (r_state == ST_INIT) begin
                r_mem[r_cnt] <= '0;
            end else if (w_accept && req_write && !w_err) begin
                for (int i = 0; i < int'(B); i++) begin
                    if (w_st_be[i]) begin
                        r_mem[w_idx][i*8 +: 8] <= w_st_data[i*8 +: 8];
                    end
                end
            end
        end
        r_pword[0] <= r_mem[w_idx];
        for (int k = 1; k < int'(READ_LAT); k++) begin
            r_pword[k] <= r_pword[k-1];
        end
    end

    // ---------------- response pipeline ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < int'(READ_LAT); k++) begin
                r_pv[k]    <= 1'b0;
                r_pe[k]    <= 1'b0;
                r_pload[k] <= 1'b0;
                r_psz[k]   <= '0;
                r_puns[k]  <= 1'b0;
                r_poff[k]  <= '0;
            end
        end else begin
            r_pv[0]    <= w_accept;
            r_pe[0]    <= w_err;
            r_pload[0] <= !req_write;
            r_psz[0]   <= req_size;
            r_puns[0]  <= req_unsigned;
            r_poff[0]  <= w_off;
            for (int k = 1; k < int'(READ_LAT); k++) begin
                r_pv[k]    <= r_pv[k-1];
                r_pe[k]    <= r_pe[k-1];
                r_pload[k] <= r_pload[k-1];
                r_psz[k]   <= r_psz[k-1];
                r_puns[k]  <= r_puns[k-1];
                r_poff[k]  <= r_poff[k-1];
            end
        end
    end

    assign resp_valid = r_pv[READ_LAT-1];
    assign resp_err   = r_pv[READ_LAT-1] && r_pe[READ_LAT-1];
    assign ReadData   = (r_pv[READ_LAT-1] && r_pload[READ_LAT-1] && !r_pe[READ_LAT-1])
                        ? w_ld_data : '0;

endmodule

// File: doc/data_mem_unit.md
# data_mem_unit

Parametrised, byte-addressable data memory for the CPU's MEM stage, succeeding the fixed 32-bit word-indexed data memory. Adds byte/halfword/word (and doubleword at 64-bit width) loads and stores with sign/zero extension, alignment and range checking, a valid/ready request handshake, and a configurable registered read latency. After reset, a hardware init sequencer zeroes the entire array before accepting requests.

## Interface
- WIDTH, 32, data width in bits; legal values 32 or 64.
- DEPTH, 512, number of WIDTH-bit words; power of two.
- READ_LAT, 1, cycles from request acceptance to response; legal 1..4.
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  1  request present.
- req_ready  out  1  unit accepts a request this cycle.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword (WIDTH = 64 only).
- req_unsigned  in  1  load zero-extends when 1, sign-extends when 0.
- Address  in  32  byte address.
- WriteData  in  WIDTH  store data, right-aligned (LSBs).
- resp_valid  out  1  response present; single-cycle pulse per accepted request.
- ReadData  out  WIDTH  load result, extended; 0 for stores and errored requests.
- resp_err  out  1  request was misaligned or out of range.
- init_done  out  1  array zeroing complete.

## Operation
- Byte lane count is B = WIDTH/8. Word index = Address >> log2(B). Byte offset = Address[log2(B)-1:0].
- States: INIT and RUN. Reset enters INIT with the counter at 0.
- In INIT, one word is written to zero per cycle at the counter index. After index DEPTH-1 is written, the unit moves to RUN and init_done goes to 1.
- req_ready = (state == RUN). A request is accepted when req_valid && req_ready.
- Error conditions:
  - Misaligned: half with offset[0] != 0; word with offset[1:0] != 0; dword with offset[2:0] != 0.
  - req_size = 3 when WIDTH = 32.
  - Out of range: word index >= DEPTH, or any Address bits above the index field nonzero.
- An errored request writes nothing and still produces a response with resp_err = 1 and ReadData = 0.
- Store: WriteData is shifted to the byte offset. Only the addressed byte enables are written; all other bytes are preserved.
- Load:
  - The addressed bytes are extracted and shifted to the LSBs.
  - Sign extension uses the top bit of the loaded field; zero extension applies when req_unsigned = 1.
  - A full-width load ignores req_unsigned.
- Stores also produce a response (write acknowledge) with ReadData = 0.
- Read-after-write: a load accepted the cycle after a store to the same word returns the stored data.
- Reset mid-operation:
  - Pipeline contents are discarded, so no response is issued for in-flight requests.
  - The unit re-enters INIT and re-zeroes the array from index 0.

## Timing
- Reset values: req_ready 0, resp_valid 0, ReadData 0, resp_err 0, init_done 0. The init counter is 0.
- INIT lasts exactly DEPTH cycles after reset deasserts. req_ready rises in the cycle after the final zero write.
- Store write happens at the rising edge on which the request is accepted.
- A response appears exactly READ_LAT cycles after acceptance, in request order. Throughput is one request per cycle.
- resp_valid has no backpressure; the consumer must always accept.
- ReadData and resp_err are valid only while resp_valid = 1, and are 0 otherwise.

## Structure
- Package data_mem_pkg holds:
  - size encodings SZ_BYTE, SZ_HALF, SZ_WORD, SZ_DWORD;
  - the state enum {ST_INIT, ST_RUN};
  - the function computing byte-enable masks from size and offset.
- Sub-module data_mem_lane_align (combinational) handles store data shift, byte-enable generation, and load extract/extend. It is instantiated once.
- Top level contains the array with per-byte write enables, the INIT counter and FSM, and a READ_LAT-deep response shift pipeline carrying valid, error, size, unsigned and offset.

## Test plan
- Init: release reset with DEPTH = 512. Require req_ready = 0 for 512 cycles, then 1, with init_done = 1. A word load of address 0x1FC returns 0x00000000.
- Byte/half store merge: store word 0x11223344 at 0x10, then byte 0xAA at 0x11, then half 0xBEEF at 0x12. A word load of 0x10 returns 0xBEEFAA44.
- Extension: after the merge, a signed byte load at 0x11 returns 0xFFFFFFAA, an unsigned byte load returns 0x000000AA, and a signed half load at 0x12 returns 0xFFFFBEEF.
- Errors:
  - A word store at 0x22 gives resp_err = 1 and word 0x20 is unchanged.
  - A load at 0x800 (DEPTH = 512) gives resp_err = 1 and ReadData = 0.
  - req_size = 3 with WIDTH = 32 gives resp_err = 1.
- Latency and RAW: with READ_LAT = 3, a store at 0x40 followed by a load at 0x40 on back-to-back cycles gives responses at +3 and +4 cycles, and the load returns the stored value.
- Reset mid-stream: assert reset with 2 loads in flight. Require no resp_valid afterward until new requests are issued, and INIT repeats for DEPTH cycles.
